// File: rtl/hex_probe_pkg.sv
// Purpose : shared constants and the active-low seven-segment encoder for the probe monitor.
// Latency : combinational helpers only.
// Backpress: none; pure definitions.
package hex_probe_pkg;

  localparam int         PAGE_W    = 8;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_F     = 7'h0E;

  // Segment order is {g,f,e,d,c,b,a}; a lit segment is driven 0.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// Purpose : synchronise and debounce one active-low push-button, emit a pulse on press.
// Latency : press pulse appears DEBOUNCE_CYCLES+2 cycles after the key goes low and stays low.
// Backpress: none; the raw key is sampled every cycle.
//
// Ports: clk/rst (sync, active-high), key_n raw active-low button,
//        press one-cycle pulse on the debounced 1->0 transition.
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          stable_q, stable_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d  = key_n;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    press_d  = 1'b0;
    if (sync2_q != stable_q) begin
      // The DEBOUNCE_CYCLES-th consecutive differing sample commits the new level.
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
        press_d  = ~sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      press_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      press_q  <= press_d;
      cnt_q    <= cnt_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/hex_probe_monitor.sv
// Purpose : page NUM_CH probe buses onto eight seven-segment digits with freeze and auto-scroll.
// Latency : hex registered, 1 cycle from probe/page/frozen; keys add debounce + 2 sync cycles.
// Backpress: none; probes are sampled every cycle, keys and auto_mode are level inputs.
//
// Ports: Clock, Reset (sync, active-high); probe channel k at [k*CH_W +: CH_W];
//        key_next_n / key_freeze_n raw active-low buttons; auto_mode scroll enable;
//        hex 8 active-low digits (digit d at [d*7 +: 7]); page selected channel; frozen.
module hex_probe_monitor
  import hex_probe_pkg::*;
#(
  parameter int NUM_CH          = 4,
  parameter int CH_W            = 16,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SCROLL_CYCLES   = 50000000
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic [NUM_CH*CH_W-1:0] probe,
  input  logic                   key_next_n,
  input  logic                   key_freeze_n,
  input  logic                   auto_mode,
  output logic [55:0]            hex,
  output logic [PAGE_W-1:0]      page,
  output logic                   frozen
);

  localparam int                TW        = $clog2(SCROLL_CYCLES);
  localparam logic [TW-1:0]     TMR_LAST  = TW'(SCROLL_CYCLES - 1);
  localparam logic [PAGE_W-1:0] LAST_PAGE = PAGE_W'(NUM_CH - 1);

  logic next_press;
  logic frz_press;

  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbnc_next (
    .clk   (Clock),
    .rst   (Reset),
    .key_n (key_next_n),
    .press (next_press)
  );

  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbnc_frz (
    .clk   (Clock),
    .rst   (Reset),
    .key_n (key_freeze_n),
    .press (frz_press)
  );

  logic                   auto1_q, auto1_d;
  logic                   auto2_q, auto2_d;
  logic [TW-1:0]          tmr_q, tmr_d;
  logic [PAGE_W-1:0]      page_q, page_d;
  logic                   frozen_q, frozen_d;
  logic [NUM_CH*CH_W-1:0] snap_q, snap_d;
  logic [55:0]            hex_q, hex_d;

  logic                   expire;
  logic                   advance;
  logic [NUM_CH*CH_W-1:0] src;
  logic [15:0]            chan_val;

  // Paging, scroll timer and freeze control.
  always_comb begin
    auto1_d  = auto_mode;
    auto2_d  = auto1_q;
    expire   = auto2_q && (tmr_q == TMR_LAST);
    // A coincident key press and expiry collapse into one advance.
    advance  = next_press || expire;

    tmr_d = tmr_q + TW'(1);
    if (!auto2_q || advance) begin
      tmr_d = '0;
    end

    page_d = page_q;
    if (advance) begin
      page_d = (page_q == LAST_PAGE) ? '0 : page_q + PAGE_W'(1);
    end

    frozen_d = frozen_q;
    snap_d   = snap_q;
    if (frz_press) begin
      frozen_d = ~frozen_q;
      if (!frozen_q) begin
        snap_d = probe;
      end
    end
  end

  // Display source and segment image, built from the current registered state.
  always_comb begin
    src      = frozen_q ? snap_q : probe;
    chan_val = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (page_q == PAGE_W'(k)) begin
        chan_val = 16'(src[k*CH_W +: CH_W]);
      end
    end
    hex_d = {hex_to_seg(page_q[7:4]),
             hex_to_seg(page_q[3:0]),
             frozen_q ? SEG_F : SEG_BLANK,
             SEG_BLANK,
             hex_to_seg(chan_val[15:12]),
             hex_to_seg(chan_val[11:8]),
             hex_to_seg(chan_val[7:4]),
             hex_to_seg(chan_val[3:0])};
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      auto1_q  <= 1'b0;
      auto2_q  <= 1'b0;
      tmr_q    <= '0;
      page_q   <= '0;
      frozen_q <= 1'b0;
      snap_q   <= '0;
      hex_q    <= '1;
    end else begin
      auto1_q  <= auto1_d;
      auto2_q  <= auto2_d;
      tmr_q    <= tmr_d;
      page_q   <= page_d;
      frozen_q <= frozen_d;
      snap_q   <= snap_d;
      hex_q    <= hex_d;
    end
  end

  assign hex    = hex_q;
  assign page   = page_q;
  assign frozen = frozen_q;

endmodule

// File: tb/tb_hex_probe_monitor.sv
// Purpose : randomized and directed bench for hex_probe_monitor against a behavioural model.
// Latency : n/a (bench).
// Backpress: n/a (bench).
module tb_hex_probe_monitor;

  localparam int NCH = 3;
  localparam int CW  = 16;
  localparam int DB  = 4;
  localparam int SC  = 8;

  logic              Clock        = 1'b0;
  logic              Reset        = 1'b1;
  logic [NCH*CW-1:0] probe        = '0;
  logic              key_next_n   = 1'b1;
  logic              key_freeze_n = 1'b1;
  logic              auto_mode    = 1'b0;
  logic [55:0]       hex;
  logic [7:0]        page;
  logic              frozen;

  always #5 Clock = ~Clock;

  hex_probe_monitor #(
    .NUM_CH          (NCH),
    .CH_W            (CW),
    .DEBOUNCE_CYCLES (DB),
    .SCROLL_CYCLES   (SC)
  ) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .probe        (probe),
    .key_next_n   (key_next_n),
    .key_freeze_n (key_freeze_n),
    .auto_mode    (auto_mode),
    .hex          (hex),
    .page         (page),
    .frozen       (frozen)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // DE2 active-low digit table, {g,f,e,d,c,b,a}.
  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  function automatic logic [55:0] mk_hex(input int pg, input bit fz, input logic [15:0] v);
    return {seg_tab[pg / 16], seg_tab[pg % 16], fz ? 7'h0E : 7'h7F, 7'h7F,
            seg_tab[v[15:12]], seg_tab[v[11:8]], seg_tab[v[7:4]], seg_tab[v[3:0]]};
  endfunction

  // Reference model: raw-sample histories (bit 0 newest) stand in for the
  // synchronisers; a level is accepted once the last DB synchronised samples
  // all disagree with the accepted level.
  logic [DB+1:0]     kn_h, kf_h;
  logic [1:0]        au_h;
  bit                m_stab_n, m_stab_f, m_prs_n, m_prs_f, m_frozen;
  int                m_page, m_since;
  logic [NCH*CW-1:0] m_snap;
  logic [55:0]       m_hex;

  task automatic tick();
    bit          expire, pn, pf;
    logic [15:0] v;
    @(posedge Clock);
    if (Reset) begin
      m_hex = '1; m_page = 0; m_frozen = 0; m_snap = '0; m_since = 0;
      m_stab_n = 1; m_stab_f = 1; m_prs_n = 0; m_prs_f = 0;
      kn_h = '1; kf_h = '1; au_h = '0;
    end else begin
      v = m_frozen ? m_snap[m_page*CW +: CW] : probe[m_page*CW +: CW];
      m_hex = mk_hex(m_page, m_frozen, v);
      expire = 0;
      if (au_h[1] == 1'b0) begin
        m_since = 0;
      end else begin
        expire  = (m_since == SC - 1);
        m_since = (m_prs_n || expire) ? 0 : m_since + 1;
      end
      if (m_prs_n || expire) m_page = (m_page + 1) % NCH;
      if (m_prs_f) begin
        if (!m_frozen) m_snap = probe;
        m_frozen = !m_frozen;
      end
      pn = 0;
      pf = 0;
      if (kn_h[DB:1] == {DB{~m_stab_n}}) begin m_stab_n = !m_stab_n; pn = !m_stab_n; end
      if (kf_h[DB:1] == {DB{~m_stab_f}}) begin m_stab_f = !m_stab_f; pf = !m_stab_f; end
      m_prs_n = pn;
      m_prs_f = pf;
      kn_h = {kn_h[DB:0], key_next_n};
      kf_h = {kf_h[DB:0], key_freeze_n};
      au_h = {au_h[0], auto_mode};
    end
    #1;
    chk("hex", hex, m_hex);
    chk("page", page, m_page);
    chk("frozen", frozen, m_frozen);
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic press_next();
    key_next_n = 1'b0; run(DB + 4);
    key_next_n = 1'b1; run(DB + 4);
  endtask

  task automatic press_frz();
    key_freeze_n = 1'b0; run(DB + 4);
    key_freeze_n = 1'b1; run(DB + 4);
  endtask

  // Ticks until page changes; gives up after 40 and records a failure.
  task automatic wait_page_change(output int n);
    logic [7:0] p0;
    p0 = page;
    n  = 0;
    while (page == p0 && n < 40) begin
      tick();
      n++;
    end
    if (page == p0) chk("page_change_timeout", 64'(n), 64'd0);
  endtask

  initial begin
    int n, pg0;

    // Reset, then first live frame of channel 0.
    probe = {16'h0000, 16'h0000, 16'h1234};
    run(2);
    chk("rst_hex", hex, {8{7'h7F}});
    Reset = 1'b0;
    tick();
    chk("first_hex", hex, {7'h40, 7'h40, 7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30, 7'h19});

    // Bounce shorter than the debounce window.
    key_next_n = 1'b0; run(3);
    key_next_n = 1'b1; run(12);
    chk("bounce_page", page, 0);

    // Held key: press lands in cycle t+2+DB, page moves on the edge closing it,
    // which is tick DB+3 counting the first sampling edge as tick 1.
    key_next_n = 1'b0;
    n = 0;
    while (page == 0 && n < 20) begin tick(); n++; end
    chk("press_lat", 64'(n), 64'(DB + 3));
    key_next_n = 1'b1; run(DB + 4);
    chk("page_1", page, 1);
    press_next();
    chk("page_2", page, 2);
    press_next();
    chk("page_wrap", page, 0);

    // Freeze channel 1 at BEEF, then change the live value.
    press_next();
    probe[31:16] = 16'hBEEF;
    run(2);
    press_frz();
    chk("frz_on", frozen, 1);
    probe[31:16] = 16'h0000;
    run(3);
    chk("frz_val", hex[27:0], {7'h03, 7'h06, 7'h06, 7'h0E});
    chk("frz_hex5", hex[41:35], 7'h0E);
    press_frz();
    chk("unfrz_val", hex[27:0], {4{7'h40}});
    chk("unfrz_hex5", hex[41:35], 7'h7F);

    // Auto-scroll period.
    auto_mode = 1'b1;
    wait_page_change(n);
    wait_page_change(n);
    chk("scroll_int_a", 64'(n), 64'(SC));
    wait_page_change(n);
    chk("scroll_int_b", 64'(n), 64'(SC));
    // Key press timed to land on the next expiry.
    tick();
    key_next_n = 1'b0;
    pg0 = int'(page);
    wait_page_change(n);
    chk("coinc_int", 64'(n), 64'(SC - 1));
    chk("coinc_step", page, (pg0 + 1) % NCH);
    key_next_n = 1'b1;
    wait_page_change(n);
    chk("coinc_next", 64'(n), 64'(SC));
    // Press one cycle before expiry restarts the period.
    key_next_n = 1'b0;
    wait_page_change(n);
    chk("mid_press_lat", 64'(n), 64'(DB + 3));
    key_next_n = 1'b1;
    wait_page_change(n);
    chk("restart_int", 64'(n), 64'(SC));
    auto_mode = 1'b0;
    run(4);

    // Randomized keys, auto mode and probes.
    for (int i = 0; i < 60; i++) begin
      key_next_n   = 1'($urandom_range(0, 1));
      key_freeze_n = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) auto_mode = ~auto_mode;
      for (int j = 0, len = $urandom_range(1, 12); j < len; j++) begin
        probe = (NCH*CW)'({$urandom(), $urandom()});
        tick();
      end
    end
    key_next_n = 1'b1; key_freeze_n = 1'b1; auto_mode = 1'b0;
    run(DB + 4);

    // Reset mid-debounce while frozen on a non-zero page.
    for (int i = 0; i < 3 && page == 0; i++) press_next();
    if (!frozen) press_frz();
    chk("pre_rst_frozen", frozen, 1);
    chk("pre_rst_page_nz", 64'(page != 0), 64'd1);
    key_next_n = 1'b0; run(3);
    Reset = 1'b1; key_next_n = 1'b1;
    tick();
    chk("rst2_hex", hex, {8{7'h7F}});
    chk("rst2_page", page, 0);
    chk("rst2_frozen", frozen, 0);
    Reset = 1'b0;
    run(DB + 6);
    chk("post_rst_page", page, 0);
    chk("post_rst_frozen", frozen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
